// File: rtl/threshold_period.sv
// Hysteresis comparator on a toggle-strobed ADC stream, plus a period meter
// that reports a 2^AVG_LOG2 moving average of the cycle count between rising crossings.
//
// state      | meaning
// CMP_LOW    | comparator below threshold, waiting for sample >= thr_high
// CMP_HIGH   | comparator above threshold, waiting for sample <= thr_low
// M_UNARMED  | no reference pulse yet (after reset or stall)
// M_RUN      | counting cycles since the last pulse
module threshold_period #(
    parameter int          ADC_WIDTH      = 12,
    parameter int          PERIOD_WIDTH   = 24,
    parameter int          AVG_LOG2       = 2,
    parameter int unsigned TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADC_WIDTH-1:0]    adc_value,
    input  logic                    adc_value_change,
    input  logic [ADC_WIDTH-1:0]    thr_high,
    input  logic [ADC_WIDTH-1:0]    thr_low,
    output logic                    pulse,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_change,
    output logic                    stalled,
    output logic                    cfg_err
);

    localparam int N  = 1 << AVG_LOG2;
    localparam int FW = AVG_LOG2 + 1;
    localparam int SW = PERIOD_WIDTH + AVG_LOG2;
    localparam logic [FW-1:0]           FILL_FULL = FW'(N);
    localparam logic [PERIOD_WIDTH-1:0] TIMEOUT   = PERIOD_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic {CMP_LOW, CMP_HIGH} cmp_t;
    typedef enum logic {M_UNARMED, M_RUN} meter_t;

    cmp_t                    cmp_state;
    meter_t                  meter_state;
    logic                    chg_q;
    logic                    accept;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic [PERIOD_WIDTH-1:0] raw_q;
    logic                    push_q;
    logic [PERIOD_WIDTH-1:0] hist [N];
    logic [PERIOD_WIDTH-1:0] oldest;
    logic [SW-1:0]           sum;
    logic [FW-1:0]           fill;

    assign accept = adc_value_change ^ chg_q;
    // Until the history is full the dropped entry contributes nothing.
    assign oldest = (fill < FILL_FULL) ? '0 : hist[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_state     <= CMP_LOW;
            meter_state   <= M_UNARMED;
            chg_q         <= 1'b0;
            cnt           <= '0;
            raw_q         <= '0;
            push_q        <= 1'b0;
            sum           <= '0;
            fill          <= '0;
            pulse         <= 1'b0;
            period        <= '0;
            period_change <= 1'b0;
            stalled       <= 1'b0;
            cfg_err       <= 1'b0;
            for (int i = 0; i < N; i++) hist[i] <= '0;
        end else begin
            chg_q   <= adc_value_change;
            cfg_err <= (thr_low >= thr_high);
            pulse   <= 1'b0;
            push_q  <= 1'b0;

            if (cfg_err) begin
                cmp_state <= CMP_LOW;
            end else if (accept) begin
                case (cmp_state)
                    CMP_LOW: if (adc_value >= thr_high) begin
                        cmp_state <= CMP_HIGH;
                        pulse     <= 1'b1;
                    end
                    CMP_HIGH: if (adc_value <= thr_low) cmp_state <= CMP_LOW;
                    default: cmp_state <= CMP_LOW;
                endcase
            end

            if (push_q) begin
                period        <= (fill < FILL_FULL) ? raw_q : PERIOD_WIDTH'(sum >> AVG_LOG2);
                period_change <= ~period_change;
            end

            case (meter_state)
                M_UNARMED: if (pulse) begin
                    meter_state <= M_RUN;
                    cnt         <= PERIOD_WIDTH'(1);
                    stalled     <= 1'b0;
                end
                M_RUN: begin
                    // A pulse coinciding with the timeout count is still a valid measurement.
                    if (pulse) begin
                        raw_q   <= cnt;
                        cnt     <= PERIOD_WIDTH'(1);
                        push_q  <= 1'b1;
                        hist[0] <= cnt;
                        for (int i = 1; i < N; i++) hist[i] <= hist[i-1];
                        sum     <= sum + SW'(cnt) - SW'(oldest);
                        if (fill < FILL_FULL) fill <= fill + 1'b1;
                    end else if (cnt == TIMEOUT) begin
                        stalled       <= 1'b1;
                        meter_state   <= M_UNARMED;
                        sum           <= '0;
                        fill          <= '0;
                        period        <= '0;
                        period_change <= ~period_change;
                        for (int i = 0; i < N; i++) hist[i] <= '0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: meter_state <= M_UNARMED;
            endcase
        end
    end

endmodule

// File: tb/tb_threshold_period.sv
// Directed bench for threshold_period: expected periods are queued by the stimulus
// and checked by a monitor on every period_change toggle.
module tb_threshold_period;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] adc_value = '0;
    logic        adc_value_change = 1'b0;
    logic [11:0] thr_high = 12'd3000;
    logic [11:0] thr_low = 12'd1000;
    logic        pulse;
    logic [23:0] period;
    logic        period_change;
    logic        stalled;
    logic        cfg_err;

    int          n_cmp = 0;
    int          n_err = 0;
    int          pulse_cnt = 0;
    int          p0;
    logic [23:0] exp_q [$];
    logic        last_pc = 1'b0;

    threshold_period #(
        .ADC_WIDTH(12), .PERIOD_WIDTH(24), .AVG_LOG2(2), .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .adc_value(adc_value), .adc_value_change(adc_value_change),
        .thr_high(thr_high), .thr_low(thr_low), .pulse(pulse), .period(period),
        .period_change(period_change), .stalled(stalled), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic sample(input logic [11:0] v);
        adc_value = v;
        adc_value_change = ~adc_value_change;
        tick();
    endtask

    task automatic samples(input logic [11:0] v, input int n);
        repeat (n) sample(v);
    endtask

    task automatic wave(input int half, input int n);
        repeat (n) begin
            samples(12'd4095, half);
            samples(12'd0, half);
        end
    endtask

    task automatic expect_period(input logic [23:0] v);
        exp_q.push_back(v);
    endtask

    // Monitor: counts pulses and checks each period update against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (pulse) pulse_cnt++;
            if (!rst_n) begin
                last_pc = 1'b0;
            end else if (period_change !== last_pc) begin
                last_pc = period_change;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL period_unexpected: got %0d, expected no update", period);
                end else begin
                    check("period", period, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        idle(3);
        check("rst_pulse", pulse, 0);
        check("rst_period", period, 0);
        check("rst_period_change", period_change, 0);
        check("rst_stalled", stalled, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;
        idle(3);

        // 1: 200-cycle period
        repeat (5) expect_period(24'd200);
        p0 = pulse_cnt;
        wave(100, 6);
        check("t1_pulses", pulse_cnt - p0, 6);

        // 2: switch to 300-cycle period, average converges
        expect_period(24'd200);
        expect_period(24'd225);
        expect_period(24'd250);
        expect_period(24'd275);
        expect_period(24'd300);
        expect_period(24'd300);
        p0 = pulse_cnt;
        wave(150, 6);
        check("t2_pulses", pulse_cnt - p0, 6);

        // 3: noisy samples, one pulse per 3100 following 900
        expect_period(24'd306);
        expect_period(24'd256);
        expect_period(24'd206);
        expect_period(24'd156);
        expect_period(24'd100);
        p0 = pulse_cnt;
        repeat (5) begin
            samples(12'd2500, 25);
            samples(12'd3100, 25);
            samples(12'd2900, 25);
            samples(12'd900, 25);
        end
        check("t3_pulses", pulse_cnt - p0, 5);

        // 4: stall, re-arm, then a fresh raw period
        expect_period(24'd93);
        expect_period(24'd0);
        expect_period(24'd50);
        sample(12'd4095);
        idle(900);
        check("t4_not_yet_stalled", stalled, 0);
        idle(200);
        check("t4_stalled", stalled, 1);
        check("t4_period_zero", period, 0);
        sample(12'd0);
        sample(12'd4095);
        sample(12'd0);
        check("t4_stall_cleared", stalled, 0);
        check("t4_period_still_zero", period, 0);
        samples(12'd0, 48);
        sample(12'd4095);

        // 5: inverted thresholds block pulses
        thr_high = 12'd1000;
        thr_low  = 12'd3000;
        idle(2);
        check("t5_cfg_err", cfg_err, 1);
        p0 = pulse_cnt;
        sample(12'd0);
        sample(12'd4095);
        sample(12'd0);
        sample(12'd4095);
        thr_high = 12'd3000;
        thr_low  = 12'd1000;
        idle(2);
        check("t5_no_pulses", pulse_cnt - p0, 0);
        check("t5_cfg_ok", cfg_err, 0);
        expect_period(24'd10);
        sample(12'd0);
        sample(12'd4095);
        samples(12'd0, 5);
        check("t5_period", period, 10);

        // 6: reset mid-run
        rst_n = 1'b0;
        adc_value_change = 1'b0;
        #1;
        check("t6_rst_pulse", pulse, 0);
        check("t6_rst_period", period, 0);
        check("t6_rst_period_change", period_change, 0);
        check("t6_rst_stalled", stalled, 0);
        check("t6_rst_cfg_err", cfg_err, 0);
        idle(3);
        rst_n = 1'b1;
        idle(2);
        expect_period(24'd20);
        sample(12'd0);
        sample(12'd4095);
        samples(12'd0, 5);
        check("t6_arm_no_update", period, 0);
        samples(12'd0, 14);
        sample(12'd4095);
        idle(5);
        check("t6_period", period, 20);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
